regfile_wb_arbiter: RTL

Write-port arbiter and scoreboard for the 32x32 MIPS register file. It shares the file's single write port between the in-order pipeline writeback (WB) and a multi-cycle multiply/divide unit (MD). It tracks registers with outstanding MD results and raises the decode-stage stall for RAW and WAW hazards. It also freezes the pipeline when MD is starved of write slots.

---
 rtl/regfile_wb_arbiter_if.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Bundles the bus-side signals of the register-file write-port arbiter.
//   wb_*      : in-order pipeline writeback request (never back-pressured)
//   md_*      : multiply/divide result handshake (md_ready returned by arbiter)
//   iss_*     : decode issuing an MD operation (marks its destination busy)
//   id_*      : decode-stage operands checked for hazards
//   stall     : decode freeze, combinational
//   pipe_hold : starvation hold, registered
//   rf_*      : registered register-file write port
// Modports: slave = arbiter side, master = pipeline/environment side.
interface regfile_wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          md_valid;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_data;
  logic          md_ready;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic          stall;
  logic          pipe_hold;
  logic          rf_we;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wd;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_valid, md_rd, md_data,
    output md_ready,
    input  iss_valid, iss_rd,
    input  id_valid, id_rs, id_rt, id_rd,
    output stall, pipe_hold,
    output rf_we, rf_rd, rf_wd
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_valid, md_rd, md_data,
    input  md_ready,
    output iss_valid, iss_rd,
    output id_valid, id_rs, id_rt, id_rd,
    input  stall, pipe_hold,
    input  rf_we, rf_rd, rf_wd
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between pipeline writeback (WB,
// always wins) and the multi-cycle multiply/divide unit (MD). Keeps a busy
// scoreboard of registers awaiting MD results, raises the decode stall on
// RAW/WAW hazards and raises pipe_hold when MD keeps losing arbitration.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : regfile_wb_arbiter_if.slave (WB/MD requests, issue/decode
//           operands, stall, pipe_hold and the registered rf_* write port)
module regfile_wb_arbiter #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   starve_cnt;
  logic [CW-1:0]   starve_nxt;
  logic            xfer;
  logic            hold_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_rd_q;
  logic [DW-1:0]   rf_wd_q;
  logic            stall_c;

  // MD only moves when WB is idle; reset blocks the handshake entirely.
  assign xfer         = rst_n & bus.md_valid & ~bus.wb_valid;
  assign bus.md_ready = xfer;

  // A register is hazardous while its MD result is outstanding, and also for
  // the one cycle its registered write is still landing in the file.
  function automatic logic hit(input logic [AW-1:0] r,
                               input logic [NREG-1:0] bsy,
                               input logic we,
                               input logic [AW-1:0] wr);
    hit = (r != '0) && (bsy[r] || (we && (wr == r)));
  endfunction

  always_comb begin
    stall_c = 1'b0;
    if (rst_n && bus.id_valid) begin
      stall_c = hit(bus.id_rs, busy, rf_we_q, rf_rd_q) |
                hit(bus.id_rt, busy, rf_we_q, rf_rd_q) |
                hit(bus.id_rd, busy, rf_we_q, rf_rd_q);
    end
  end

  assign bus.stall = stall_c;

  // Scoreboard update: the clear is applied first so a same-index issue wins.
  always_comb begin
    busy_nxt = busy;
    if (xfer) begin
      busy_nxt[bus.md_rd] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_rd != '0)) begin
      busy_nxt[bus.iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Losing cycles counter, saturating so pipe_hold stays asserted until MD gets in.
  always_comb begin
    starve_nxt = starve_cnt;
    if (xfer) begin
      starve_nxt = '0;
    end else if (bus.md_valid && bus.wb_valid && (starve_cnt != CNT_MAX)) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      starve_cnt <= '0;
      hold_q     <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      starve_cnt <= starve_nxt;
      if (xfer) begin
        hold_q <= 1'b0;
      end else if (starve_nxt == CNT_MAX) begin
        hold_q <= 1'b1;
      end
    end
  end

  // Write port: r0 writes are swallowed, leaving index/data at their old values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else if (bus.wb_valid) begin
      rf_we_q <= (bus.wb_rd != '0);
      if (bus.wb_rd != '0) begin
        rf_rd_q <= bus.wb_rd;
        rf_wd_q <= bus.wb_data;
      end
    end else if (xfer) begin
      rf_we_q <= (bus.md_rd != '0);
      if (bus.md_rd != '0) begin
        rf_rd_q <= bus.md_rd;
        rf_wd_q <= bus.md_data;
      end
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign bus.pipe_hold = hold_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;

endmodule
